// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester valid/ready arbiter and sequencer for the shared 16-bit ALU.
// Latency: response pulse ALU_LAT+1 cycles after the request handshake; one op per ALU_LAT+2 cycles.
// Backpressure: req_ready only in IDLE, to the arbitration winner; responses cannot be stalled.
// Build option ALU_ARB_FIXED_PRI_EN: requester 0 always wins ties (default build is round-robin).
// ALU_LAT legal range is 1..15 (cnt is 4 bits).
module alu_arbiter #(
   parameter int ALU_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_0,
   input  logic        req_valid_1,
   output logic        req_ready_0,
   output logic        req_ready_1,
   input  logic [3:0]  req_funct_0,
   input  logic [3:0]  req_funct_1,
   input  logic [15:0] req_op1_0,
   input  logic [15:0] req_op1_1,
   input  logic [15:0] req_op2_0,
   input  logic [15:0] req_op2_1,
   output logic        rsp_valid_0,
   output logic        rsp_valid_1,
   output logic [15:0] rsp_result,
   output logic [15:0] rsp_remainder,
   output logic        rsp_ovf,
   output logic        busy,
   output logic        alu_rst,
   output logic [3:0]  alu_funct,
   output logic [15:0] alu_op1,
   output logic [15:0] alu_op2,
   input  logic [15:0] alu_result,
   input  logic [15:0] alu_remainder,
   input  logic        alu_o
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   // Count value at which the ALU outputs are sampled (the ALU_LAT-th edge with alu_rst low).
   localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;   // 1: requester 1 was granted last
   logic        owner_q, owner_d;             // requester that owns the in-flight op
   logic [3:0]  cnt_q, cnt_d;
   logic        alu_rst_q, alu_rst_d;
   logic [3:0]  alu_funct_q, alu_funct_d;
   logic [15:0] alu_op1_q, alu_op1_d;
   logic [15:0] alu_op2_q, alu_op2_d;
   logic [15:0] rsp_result_q, rsp_result_d;
   logic [15:0] rsp_remainder_q, rsp_remainder_d;
   logic        rsp_ovf_q, rsp_ovf_d;
   logic        rsp_valid_0_q, rsp_valid_0_d;
   logic        rsp_valid_1_q, rsp_valid_1_d;

   logic        grant_0, grant_1;
   logic        hs_0, hs_1;

   // Arbitration: sole requester wins; on a tie the requester not granted last wins (or 0 if fixed).
   always_comb begin
      grant_0 = 1'b0;
      grant_1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRI_EN
      grant_0 = req_valid_0;
`else
      grant_0 = req_valid_0 && (!req_valid_1 || last_grant_q);
`endif
      grant_1 = req_valid_1 && !grant_0;
   end

   assign req_ready_0 = (state_q == IDLE) && grant_0 && !rst;
   assign req_ready_1 = (state_q == IDLE) && grant_1 && !rst;
   assign hs_0        = req_ready_0 && req_valid_0;
   assign hs_1        = req_ready_1 && req_valid_1;

   // Sequencer next state: launch on handshake, count ALU latency, capture, pulse response.
   always_comb begin
      state_d         = state_q;
      last_grant_d    = last_grant_q;
      owner_d         = owner_q;
      cnt_d           = cnt_q;
      alu_rst_d       = alu_rst_q;
      alu_funct_d     = alu_funct_q;
      alu_op1_d       = alu_op1_q;
      alu_op2_d       = alu_op2_q;
      rsp_result_d    = rsp_result_q;
      rsp_remainder_d = rsp_remainder_q;
      rsp_ovf_d       = rsp_ovf_q;
      rsp_valid_0_d   = 1'b0;
      rsp_valid_1_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (hs_0 || hs_1) begin
               alu_funct_d  = hs_1 ? req_funct_1 : req_funct_0;
               alu_op1_d    = hs_1 ? req_op1_1   : req_op1_0;
               alu_op2_d    = hs_1 ? req_op2_1   : req_op2_0;
               last_grant_d = hs_1;
               owner_d      = hs_1;
               cnt_d        = 4'd0;
               alu_rst_d    = 1'b0;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
               rsp_result_d    = alu_result;
               rsp_remainder_d = alu_remainder;
               rsp_ovf_d       = alu_o;
               rsp_valid_0_d   = !owner_q;
               rsp_valid_1_d   = owner_q;
               alu_rst_d       = 1'b1;
               state_d         = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            alu_rst_d = 1'b1;
         end
      endcase
   end

   // State and registered outputs; reset drops any in-flight operation and parks the ALU in reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         last_grant_q    <= 1'b1;
         owner_q         <= 1'b0;
         cnt_q           <= 4'd0;
         alu_rst_q       <= 1'b1;
         alu_funct_q     <= 4'd0;
         alu_op1_q       <= 16'd0;
         alu_op2_q       <= 16'd0;
         rsp_result_q    <= 16'd0;
         rsp_remainder_q <= 16'd0;
         rsp_ovf_q       <= 1'b0;
         rsp_valid_0_q   <= 1'b0;
         rsp_valid_1_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         last_grant_q    <= last_grant_d;
         owner_q         <= owner_d;
         cnt_q           <= cnt_d;
         alu_rst_q       <= alu_rst_d;
         alu_funct_q     <= alu_funct_d;
         alu_op1_q       <= alu_op1_d;
         alu_op2_q       <= alu_op2_d;
         rsp_result_q    <= rsp_result_d;
         rsp_remainder_q <= rsp_remainder_d;
         rsp_ovf_q       <= rsp_ovf_d;
         rsp_valid_0_q   <= rsp_valid_0_d;
         rsp_valid_1_q   <= rsp_valid_1_d;
      end
   end

   assign busy          = (state_q != IDLE);
   assign alu_rst       = alu_rst_q;
   assign alu_funct     = alu_funct_q;
   assign alu_op1       = alu_op1_q;
   assign alu_op2       = alu_op2_q;
   assign rsp_result    = rsp_result_q;
   assign rsp_remainder = rsp_remainder_q;
   assign rsp_ovf       = rsp_ovf_q;
   assign rsp_valid_0   = rsp_valid_0_q;
   assign rsp_valid_1   = rsp_valid_1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioral ALU on each instance.
// Main instance uses ALU_LAT=2; a second instance uses ALU_LAT=1 for the short-latency timing.
// Expected results are hand-computed constants in the vector table.
module tb_alu_arbiter;

   localparam int LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   // ---------------- ALU_LAT=2 instance ----------------
   logic        v0, v1, rdy0, rdy1, rv0, rv1, ovf, busy, alu_rst, alu_o;
   logic [3:0]  f0, f1, alu_funct;
   logic [15:0] a0, b0, a1, b1, res, rem, alu_op1, alu_op2, alu_result, alu_rem;
   logic [32:0] m2;

   alu_arbiter #(.ALU_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid_0(v0), .req_valid_1(v1), .req_ready_0(rdy0), .req_ready_1(rdy1),
      .req_funct_0(f0), .req_funct_1(f1),
      .req_op1_0(a0), .req_op1_1(a1), .req_op2_0(b0), .req_op2_1(b1),
      .rsp_valid_0(rv0), .rsp_valid_1(rv1),
      .rsp_result(res), .rsp_remainder(rem), .rsp_ovf(ovf), .busy(busy),
      .alu_rst(alu_rst), .alu_funct(alu_funct), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_result(alu_result), .alu_remainder(alu_rem), .alu_o(alu_o)
   );

   // ---------------- ALU_LAT=1 instance (requester 0 only) ----------------
   logic        l_v0, l_rdy0, l_rdy1, l_rv0, l_rv1, l_ovf, l_busy, l_alu_rst, l_alu_o;
   logic [3:0]  l_f0, l_alu_funct;
   logic [15:0] l_a0, l_b0, l_res, l_rem, l_alu_op1, l_alu_op2, l_alu_result, l_alu_rem;
   logic [32:0] m1;

   alu_arbiter #(.ALU_LAT(1)) u_dut_lat1 (
      .clk(clk), .rst(rst),
      .req_valid_0(l_v0), .req_valid_1(1'b0), .req_ready_0(l_rdy0), .req_ready_1(l_rdy1),
      .req_funct_0(l_f0), .req_funct_1(4'd0),
      .req_op1_0(l_a0), .req_op1_1(16'd0), .req_op2_0(l_b0), .req_op2_1(16'd0),
      .rsp_valid_0(l_rv0), .rsp_valid_1(l_rv1),
      .rsp_result(l_res), .rsp_remainder(l_rem), .rsp_ovf(l_ovf), .busy(l_busy),
      .alu_rst(l_alu_rst), .alu_funct(l_alu_funct), .alu_op1(l_alu_op1), .alu_op2(l_alu_op2),
      .alu_result(l_alu_result), .alu_remainder(l_alu_rem), .alu_o(l_alu_o)
   );

   // Behavioral ALU: add/mult with 16-bit wrap; returns {ovf, remainder, result}.
   function automatic logic [32:0] alu_model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] sa, sb, p;
      logic [15:0] s;
      logic        ov;
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      case (f)
         4'b0000: begin
            s  = a + b;
            ov = (a[15] == b[15]) && (s[15] != a[15]);
            return {ov, 16'h0000, s};
         end
         4'b0100: begin
            p  = sa * sb;
            ov = (p != {{16{p[15]}}, p[15:0]});
            return {ov, p[31:16], p[15:0]};
         end
         default: return 33'h0;
      endcase
   endfunction

   // ALU outputs are meaningless (zero) while the ALU is held in reset.
   always_comb m2 = alu_rst ? 33'h0 : alu_model(alu_funct, alu_op1, alu_op2);
   always_comb m1 = l_alu_rst ? 33'h0 : alu_model(l_alu_funct, l_alu_op1, l_alu_op2);
   assign {alu_o, alu_rem, alu_result}       = m2;
   assign {l_alu_o, l_alu_rem, l_alu_result} = m1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        port;
      logic [3:0]  funct;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [15:0] rem;
      logic        ovf;
   } vec_t;

   vec_t vecs[6];

   // One complete operation on the LAT=2 instance with cycle-exact checks of the handshake and response.
   task automatic run_op(input vec_t v, input string tag);
      @(posedge clk); #1;
      if (v.port) begin v1 = 1'b1; f1 = v.funct; a1 = v.a; b1 = v.b; end
      else        begin v0 = 1'b1; f0 = v.funct; a0 = v.a; b0 = v.b; end
      @(negedge clk);
      chk({tag, ".ready"}, {30'd0, rdy1, rdy0}, v.port ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      v0 = 1'b0; v1 = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         chk($sformatf("%s.exec%0d_alu_rst", tag, k), alu_rst, 0);
         chk($sformatf("%s.exec%0d_rsp_valid", tag, k), {30'd0, rv1, rv0}, 0);
         if (k == 1) chk({tag, ".alu_ops"}, {alu_funct, alu_op1, alu_op2[11:0]}, {v.funct, v.a, v.b[11:0]});
      end
      @(negedge clk);
      chk({tag, ".rsp_valid"}, {30'd0, rv1, rv0}, v.port ? 32'd2 : 32'd1);
      chk({tag, ".resp_alu_rst"}, alu_rst, 1);
      chk({tag, ".result"}, res, v.res);
      chk({tag, ".remainder"}, rem, v.rem);
      chk({tag, ".ovf"}, ovf, v.ovf);
      @(negedge clk);
      chk({tag, ".rsp_pulse_end"}, {30'd0, rv1, rv0}, 0);
      chk({tag, ".idle_busy"}, busy, 0);
   endtask

   int g_port[4];
   int g_cyc[4];
   int exp_g[4];
   int n_g;
   int l_rdy_cyc[3];
   int n_lr;
   int l_rsp_cyc;
   logic [15:0] l_rsp_res;
   int seen_rv;
   int both_rdy;

   initial begin
      //               port funct    a        b        res      rem      ovf
      vecs[0] = '{1'b0, 4'b0000, 16'h1111, 16'h8888, 16'h9999, 16'h0000, 1'b0};
      vecs[1] = '{1'b1, 4'b0100, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 1'b0};
      vecs[2] = '{1'b0, 4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b1};
      vecs[3] = '{1'b1, 4'b0100, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 1'b1};
      vecs[4] = '{1'b1, 4'b0100, 16'hFFFF, 16'h0002, 16'hFFFE, 16'hFFFF, 1'b0};
      vecs[5] = '{1'b0, 4'b0000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b1};
`ifdef ALU_ARB_FIXED_PRI_EN
      exp_g = '{0, 0, 0, 0};
`else
      exp_g = '{0, 1, 0, 1};
`endif

      // Reset with both requesters valid: nothing may be accepted.
      rst = 1'b1;
      v0 = 1'b1; v1 = 1'b1; f0 = 4'd0; f1 = 4'd0; a0 = 16'd0; b0 = 16'd0; a1 = 16'd0; b1 = 16'd0;
      l_v0 = 1'b0; l_f0 = 4'd0; l_a0 = 16'd0; l_b0 = 16'd0;
      repeat (2) @(negedge clk);
      chk("reset.ready", {30'd0, rdy1, rdy0}, 0);
      chk("reset.busy", busy, 0);
      chk("reset.alu_rst", alu_rst, 1);
      chk("reset.alu_regs", {12'd0, alu_funct, alu_op1}, 0);
      chk("reset.alu_op2", alu_op2, 0);
      chk("reset.rsp", {rem, res}, 0);
      chk("reset.rsp_flags", {29'd0, ovf, rv1, rv0}, 0);
      v0 = 1'b0; v1 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Table-driven single operations.
      for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));
      chk("hold.alu_op1", alu_op1, vecs[5].a);
      chk("hold.rsp_result", res, vecs[5].res);

      // Both requesters valid continuously: grant order and spacing.
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      f0 = 4'b0000; a0 = 16'h0001; b0 = 16'h0001;
      f1 = 4'b0000; a1 = 16'h0002; b1 = 16'h0002;
      v0 = 1'b1; v1 = 1'b1;
      n_g = 0; both_rdy = 0;
      for (int k = 0; k < 40 && n_g < 4; k++) begin
         @(negedge clk);
         if (rdy0 && rdy1) both_rdy++;
         if (rdy0 || rdy1) begin
            g_port[n_g] = rdy1 ? 1 : 0;
            g_cyc[n_g]  = cyc;
            n_g++;
         end
      end
      @(posedge clk); #1;
      v0 = 1'b0; v1 = 1'b0;
      chk("tie.grant_count", n_g, 4);
      chk("tie.both_ready", both_rdy, 0);
      for (int i = 0; i < n_g; i++) chk($sformatf("tie.grant%0d", i), g_port[i], exp_g[i]);
      for (int i = 1; i < n_g; i++) chk($sformatf("tie.spacing%0d", i), g_cyc[i] - g_cyc[i-1], LAT + 2);
      repeat (LAT + 3) @(negedge clk);

      // Reset pulsed during EXEC: operation dropped, outputs back to reset values.
      @(posedge clk); #1;
      v0 = 1'b1; f0 = 4'b0000; a0 = 16'h1111; b0 = 16'h8888;
      @(posedge clk); #1;
      v0 = 1'b0;
      @(negedge clk);
      chk("midrst.busy_before", busy, 1);
      rst = 1'b1;
      #1;
      chk("midrst.busy", busy, 0);
      chk("midrst.alu_rst", alu_rst, 1);
      chk("midrst.alu_op1", alu_op1, 0);
      chk("midrst.rsp", {ovf, res}, 0);
      chk("midrst.ready", {30'd0, rdy1, rdy0}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen_rv = 0;
      for (int k = 0; k < LAT + 3; k++) begin
         @(negedge clk);
         if (rv0 || rv1) seen_rv++;
      end
      chk("midrst.no_rsp", seen_rv, 0);
      run_op(vecs[0], "post_rst");

      // ALU_LAT=1 instance: response timing and back-to-back acceptance.
      @(posedge clk); #1;
      l_v0 = 1'b1; l_f0 = 4'b0000; l_a0 = 16'h0005; l_b0 = 16'h0003;
      n_lr = 0; l_rsp_cyc = -1; l_rsp_res = 16'd0;
      for (int k = 0; k < 20 && n_lr < 3; k++) begin
         @(negedge clk);
         if (l_rdy0) begin
            l_rdy_cyc[n_lr] = cyc;
            n_lr++;
         end
         if (l_rv0 && l_rsp_cyc < 0) begin
            l_rsp_cyc = cyc;
            l_rsp_res = l_res;
         end
      end
      @(posedge clk); #1;
      l_v0 = 1'b0;
      chk("lat1.accept_count", n_lr, 3);
      chk("lat1.rsp_delay", l_rsp_cyc - l_rdy_cyc[0], 2);
      chk("lat1.result", l_rsp_res, 16'h0008);
      for (int i = 1; i < n_lr; i++) chk($sformatf("lat1.spacing%0d", i), l_rdy_cyc[i] - l_rdy_cyc[i-1], 3);
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared 16-bit ALU. It accepts operation requests from two independent requesters over valid/ready handshakes and grants the ALU round-robin. It drives the ALU's function code, operands and reset, waits a fixed latency, then captures result/remainder/overflow and returns them to the owning requester. It sits between the instruction-issue logic and the ALU, and replaces direct toggling of the ALU's reset by each requester.

## Interface
Parameters:
- ALU_LAT, 2: clock edges the ALU needs, with its reset low and operands stable, before its outputs are valid; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid_0 / req_valid_1  in  1  requester has an operation pending
- req_ready_0 / req_ready_1  out  1  arbiter accepts this cycle; a transfer occurs when valid&&ready at a rising edge
- req_funct_0 / req_funct_1  in  4  ALU function code (0000 add, 0100 mult, ...)
- req_op1_0 / req_op1_1, req_op2_0 / req_op2_1  in  16  signed operands
- rsp_valid_0 / rsp_valid_1  out  1  one-cycle pulse; response fields are valid
- rsp_result, rsp_remainder  out  16  captured ALU result and remainder, shared by both requesters
- rsp_ovf  out  1  captured ALU overflow
- busy  out  1  an operation is in flight (state != IDLE)
- alu_rst  out  1  drives the ALU reset; high whenever the ALU is not executing
- alu_funct  out  4, alu_op1 / alu_op2  out  16  registered ALU operands
- alu_result / alu_remainder  in  16, alu_o  in  1  ALU outputs

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: arbitrate. A grant goes to the only valid requester. If both are valid, the grant goes to the requester other than last_grant. req_ready_x = (state==IDLE) && grant_x && !rst; ready is combinational from valid.
- On handshake: register funct/op1/op2 into alu_* outputs, set last_grant and owner, clear cnt, and go to EXEC.
- EXEC: alu_rst=0. cnt increments each edge. At the edge where cnt==ALU_LAT-1, capture alu_result/alu_remainder/alu_o into rsp_* and go to RESP.
- RESP: rsp_valid_owner=1 for exactly one cycle and alu_rst=1. The next state is IDLE. No request is accepted in RESP.
- There is no response back-pressure; requesters must consume the rsp_valid pulse.
- rsp_* fields hold their value until the next capture. alu_* operand registers hold until the next handshake.
- Widths: data passes through unmodified; the arbiter performs no arithmetic on it. cnt is 4 bits.
- Reset values: state=IDLE, last_grant=1 (so requester 0 wins the first tie), cnt=0, alu_rst=1, alu_funct/op1/op2=0, rsp_*=0, rsp_valid_*=0, busy=0, req_ready_*=0.

## Timing
- Handshake at edge E0, then EXEC for ALU_LAT cycles, then RESP. rsp_valid rises ALU_LAT+1 cycles after E0.
- Sustained throughput is one operation per ALU_LAT+2 cycles.
- alu_rst falls in the cycle after E0 and rises in RESP.
- A requester whose valid drops in IDLE before a handshake loses nothing; requests must stay stable until ready.
- Reset asserted mid-EXEC or mid-RESP: the FSM returns to IDLE immediately and the in-flight operation is dropped with no rsp_valid. alu_rst=1 asynchronously and all outputs take their reset values.
- A request arriving while busy waits. The winner is decided on the first IDLE cycle by the tie rule.

## Configuration
- ALU_ARB_FIXED_PRI_EN defined: fixed priority. Requester 0 always wins when both are valid, and last_grant is unused for arbitration.
- ALU_ARB_FIXED_PRI_EN undefined (default): round-robin as described in Operation.

## Test plan
The bench uses a behavioral ALU model: add/mult with 16-bit wrap and signed overflow, outputs valid ALU_LAT edges after rst falls. ALU_LAT=2 unless stated.
- Req0 add, op1=1111 op2=8888: ready_0 in the same cycle, alu_rst low for 2 cycles, rsp_valid_0 pulses 3 cycles after the handshake with rsp_result=9999, rsp_ovf=0, rsp_valid_1=0.
- Req1 mult, op1=0001 op2=0001: rsp_valid_1 pulses with rsp_result=0001 and rsp_remainder per the model.
- Both requesters valid continuously, 4 operations: grants alternate 0,1,0,1. With ALU_ARB_FIXED_PRI_EN the grants are 0,0,0,0 while req_valid_0 stays high.
- Req0 add 7FFF+0001: rsp_result=8000, rsp_ovf=1.
- Reset pulsed during EXEC: no rsp_valid, busy=0, alu_rst=1. A subsequent req0 add completes normally.
- ALU_LAT=1 rebuild: rsp_valid arrives 2 cycles after the handshake, and back-to-back requests are accepted every 3 cycles.
